// File: rtl/csr_issue_if.sv
// Handshake and CSR-file bus for the SYSTEM-instruction issue stage.
// The slave modport is the issue stage; master is the upstream/CSR-file/writeback side.
interface csr_issue_if;
  // instruction input handshake
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_val;
  logic [31:0] in_pc;
  logic [1:0]  priv_mode;
  // command bus into the CSR register file
  logic [11:0] csr;
  logic [31:0] write_data;
  logic [31:0] pc;
  logic        is_csrrw;
  logic        is_csrrs;
  logic        is_csrrc;
  logic        is_csrrwi;
  logic        is_csrrsi;
  logic        is_csrrci;
  logic        is_ebreak;
  logic        is_ecall;
  logic        is_mret;
  logic [31:0] csr_read_data;
  // rd writeback handshake
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  modport slave (
    input  in_valid, in_instr, in_rs1_val, in_pc, priv_mode, csr_read_data, wb_ready,
    output in_ready, csr, write_data, pc,
    output is_csrrw, is_csrrs, is_csrrc, is_csrrwi, is_csrrsi, is_csrrci,
    output is_ebreak, is_ecall, is_mret,
    output wb_valid, wb_we, wb_rd, wb_data, illegal
  );

  modport master (
    output in_valid, in_instr, in_rs1_val, in_pc, priv_mode, csr_read_data, wb_ready,
    input  in_ready, csr, write_data, pc,
    input  is_csrrw, is_csrrs, is_csrrc, is_csrrwi, is_csrrsi, is_csrrci,
    input  is_ebreak, is_ecall, is_mret,
    input  wb_valid, wb_we, wb_rd, wb_data, illegal
  );
endinterface

// File: rtl/csr_issue.sv
// SYSTEM-instruction issue stage: decodes CSR/ecall/ebreak/mret, checks legality,
// fires one command strobe into the CSR file and returns the old CSR value for rd.
module csr_issue (
  input logic        clk,
  input logic        rst_n,
  csr_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic csrrw;
    logic csrrs;
    logic csrrc;
    logic csrrwi;
    logic csrrsi;
    logic csrrci;
    logic ebreak;
    logic ecall;
    logic mret;
  } strobe_t;

  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
  localparam logic [31:0] WORD_MRET   = 32'h3020_0073;

  state_t      state_q, state_d;
  logic [11:0] csr_q, csr_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] pc_q, pc_d;
  strobe_t     strobe_q, strobe_d;
  logic        we_q, we_d;
  logic [4:0]  rd_q, rd_d;
  logic        illegal_q, illegal_d;
  logic [31:0] data_q, data_d;

  // Decode of the offered instruction, registered only on accept.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_field;
  logic [4:0]  rs1_field;
  logic [11:0] csr_field;
  logic        eff_write;
  strobe_t     dec_strobe;
  logic        dec_illegal;
  logic        dec_we;
  logic [31:0] dec_write_data;

  assign opcode    = bus.in_instr[6:0];
  assign rd_field  = bus.in_instr[11:7];
  assign funct3    = bus.in_instr[14:12];
  assign rs1_field = bus.in_instr[19:15];
  assign csr_field = bus.in_instr[31:20];

  // Set/clear forms with a zero rs1 field (register or zimm) are pure reads.
  assign eff_write = (funct3[1:0] == 2'b01) || (rs1_field != 5'd0);

  assign dec_write_data = funct3[2] ? {27'd0, rs1_field} : bus.in_rs1_val;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    dec_strobe  = '0;
    dec_illegal = 1'b0;
    dec_we      = 1'b0;
    if (opcode != OPC_SYSTEM) begin
      dec_illegal = 1'b1;
    end else if (funct3 == 3'b100) begin
      dec_illegal = 1'b1;
    end else if (funct3 == 3'b000) begin
      case (bus.in_instr)
        WORD_ECALL:  dec_strobe.ecall  = 1'b1;
        WORD_EBREAK: dec_strobe.ebreak = 1'b1;
        WORD_MRET: begin
          if (bus.priv_mode != 2'b11) dec_illegal = 1'b1;
          else                        dec_strobe.mret = 1'b1;
        end
        default:     dec_illegal = 1'b1;
      endcase
    end else if (bus.priv_mode < csr_field[9:8]) begin
      dec_illegal = 1'b1;
    end else if (eff_write && (csr_field[11:10] == 2'b11)) begin
      dec_illegal = 1'b1;
    end else begin
      dec_we = (rd_field != 5'd0);
      if (eff_write) begin
        case (funct3)
          3'b001:  dec_strobe.csrrw  = 1'b1;
          3'b010:  dec_strobe.csrrs  = 1'b1;
          3'b011:  dec_strobe.csrrc  = 1'b1;
          3'b101:  dec_strobe.csrrwi = 1'b1;
          3'b110:  dec_strobe.csrrsi = 1'b1;
          default: dec_strobe.csrrci = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    csr_d        = csr_q;
    write_data_d = write_data_q;
    pc_d         = pc_q;
    strobe_d     = strobe_q;
    we_d         = we_q;
    rd_d         = rd_q;
    illegal_d    = illegal_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          csr_d        = csr_field;
          write_data_d = dec_write_data;
          pc_d         = bus.in_pc;
          strobe_d     = dec_strobe;
          we_d         = dec_we;
          rd_d         = rd_field;
          illegal_d    = dec_illegal;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        data_d  = illegal_q ? 32'd0 : bus.csr_read_data;
        state_d = RESP;
      end
      RESP: begin
        if (bus.wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      csr_q        <= '0;
      write_data_q <= '0;
      pc_q         <= '0;
      strobe_q     <= '0;
      we_q         <= 1'b0;
      rd_q         <= '0;
      illegal_q    <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      csr_q        <= csr_d;
      write_data_q <= write_data_d;
      pc_q         <= pc_d;
      strobe_q     <= strobe_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      illegal_q    <= illegal_d;
      data_q       <= data_d;
    end
  end

  // Strobes are gated by state so an asynchronous reset drops them immediately.
  strobe_t strobe_out;
  assign strobe_out = (state_q == ISSUE) ? strobe_q : '0;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.csr        = csr_q;
  assign bus.write_data = write_data_q;
  assign bus.pc         = pc_q;
  assign bus.is_csrrw   = strobe_out.csrrw;
  assign bus.is_csrrs   = strobe_out.csrrs;
  assign bus.is_csrrc   = strobe_out.csrrc;
  assign bus.is_csrrwi  = strobe_out.csrrwi;
  assign bus.is_csrrsi  = strobe_out.csrrsi;
  assign bus.is_csrrci  = strobe_out.csrrci;
  assign bus.is_ebreak  = strobe_out.ebreak;
  assign bus.is_ecall   = strobe_out.ecall;
  assign bus.is_mret    = strobe_out.mret;
  assign bus.wb_valid   = (state_q == RESP);
  assign bus.wb_we      = (state_q == RESP) && we_q;
  assign bus.illegal    = (state_q == RESP) && illegal_q;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = data_q;

endmodule

// File: tb/tb_csr_issue.sv
// Directed bench for csr_issue: a small CSR-file model answers reads and applies strobes,
// and each step checks issue-cycle strobes and the writeback result against fixed values.
module tb_csr_issue;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  csr_issue_if bus ();

  csr_issue u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector order: {rw, rs, rc, rwi, rsi, rci, ebreak, ecall, mret}
  localparam logic [8:0] SB_NONE   = 9'h000;
  localparam logic [8:0] SB_RW     = 9'h100;
  localparam logic [8:0] SB_RC     = 9'h040;
  localparam logic [8:0] SB_RSI    = 9'h010;
  localparam logic [8:0] SB_EBREAK = 9'h004;
  localparam logic [8:0] SB_ECALL  = 9'h002;
  localparam logic [8:0] SB_MRET   = 9'h001;

  // Minimal CSR file: three writable registers and one read-only id register.
  logic [31:0] mscratch = 32'h0000_0011;
  logic [31:0] mstatus  = 32'h0000_1800;
  logic [31:0] mie      = 32'h0000_0000;

  logic [8:0] sb;
  assign sb = {bus.is_csrrw, bus.is_csrrs, bus.is_csrrc, bus.is_csrrwi, bus.is_csrrsi,
               bus.is_csrrci, bus.is_ebreak, bus.is_ecall, bus.is_mret};

  always_comb begin
    case (bus.csr)
      12'h340: bus.csr_read_data = mscratch;
      12'h300: bus.csr_read_data = mstatus;
      12'h304: bus.csr_read_data = mie;
      12'hF11: bus.csr_read_data = 32'h0000_0055;
      default: bus.csr_read_data = 32'h0000_0000;
    endcase
  end

  function automatic logic [31:0] upd(input logic [31:0] old, input logic [31:0] wd,
                                      input logic [8:0] s);
    if (s[8] || s[5])      return wd;
    else if (s[7] || s[4]) return old | wd;
    else if (s[6] || s[3]) return old & ~wd;
    return old;
  endfunction

  always @(posedge clk) begin
    if (bus.csr == 12'h340) mscratch <= upd(mscratch, bus.write_data, sb);
    if (bus.csr == 12'h300) mstatus  <= upd(mstatus,  bus.write_data, sb);
    if (bus.csr == 12'h304) mie      <= upd(mie,      bus.write_data, sb);
  end

  function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {a, rs1, f3, rd, 7'b1110011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction from IDLE through writeback; chk_cw enables csr/write_data checks.
  task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] rs1v,
                        input logic [31:0] pcv, input logic [1:0] priv, input logic [8:0] exp_sb,
                        input logic chk_cw, input logic [11:0] exp_csr, input logic [31:0] exp_wd,
                        input logic exp_we, input logic [4:0] exp_rd, input logic [31:0] exp_data,
                        input logic exp_ill, input int stall);
    int n = 0;
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_instr   = instr;
    bus.in_rs1_val = rs1v;
    bus.in_pc      = pcv;
    bus.priv_mode  = priv;
    bus.wb_ready   = (stall == 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_issue_strobe"}, 32'(sb), 32'(exp_sb));
    check({tag, "_issue_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_issue_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    check({tag, "_issue_pc"}, bus.pc, pcv);
    if (chk_cw) begin
      check({tag, "_issue_csr"}, 32'(bus.csr), 32'(exp_csr));
      check({tag, "_issue_wdata"}, bus.write_data, exp_wd);
    end
    @(negedge clk);
    check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    check({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(exp_rd));
    check({tag, "_wb_we"}, 32'(bus.wb_we), 32'(exp_we));
    check({tag, "_wb_data"}, bus.wb_data, exp_data);
    check({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_ill));
    check({tag, "_resp_strobe"}, 32'(sb), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_wb_valid"}, 32'(bus.wb_valid), 32'd1);
      check({tag, "_stall_wb_data"}, bus.wb_data, exp_data);
      check({tag, "_stall_wb_rd"}, 32'(bus.wb_rd), 32'(exp_rd));
      check({tag, "_stall_wb_we"}, 32'(bus.wb_we), 32'(exp_we));
      check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_stall_strobe"}, 32'(sb), 32'd0);
      if (chk_cw) check({tag, "_stall_csr"}, 32'(bus.csr), 32'(exp_csr));
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    check({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_rs1_val = '0;
    bus.in_pc      = '0;
    bus.priv_mode  = 2'b11;
    bus.wb_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_strobe", 32'(sb), 32'd0);
    check("rst_csr", 32'(bus.csr), 32'd0);
    check("rst_wdata", bus.write_data, 32'd0);
    check("rst_pc", bus.pc, 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_we", 32'(bus.wb_we), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //       tag          instr                          rs1v          pc            priv   strobe     cw    csr      wdata         we    rd     data          ill  stall
    run_op("csrrw",      enc(12'h340, 5'd6, 3'b001, 5'd5), 32'hDEADBEEF, 32'h100, 2'b11, SB_RW,     1'b1, 12'h340, 32'hDEADBEEF, 1'b1, 5'd5, 32'h0000_0011, 1'b0, 0);
    check("mscratch_written", mscratch, 32'hDEADBEEF);
    run_op("csrrs_x0",   enc(12'h300, 5'd0, 3'b010, 5'd7), 32'hFFFFFFFF, 32'h104, 2'b11, SB_NONE,   1'b1, 12'h300, 32'hFFFFFFFF, 1'b1, 5'd7, 32'h0000_1800, 1'b0, 0);
    run_op("csrrci_z0",  enc(12'h300, 5'd0, 3'b111, 5'd0), 32'h12345678, 32'h108, 2'b11, SB_NONE,   1'b1, 12'h300, 32'h00000000, 1'b0, 5'd0, 32'h0000_1800, 1'b0, 0);
    check("mstatus_kept", mstatus, 32'h0000_1800);
    run_op("csrrsi",     enc(12'h304, 5'h1F, 3'b110, 5'd1), 32'h0,       32'h10C, 2'b11, SB_RSI,    1'b1, 12'h304, 32'h0000001F, 1'b1, 5'd1, 32'h0000_0000, 1'b0, 0);
    run_op("ro_write",   enc(12'hF11, 5'd2, 3'b001, 5'd1), 32'h00000099, 32'h110, 2'b11, SB_NONE,   1'b0, 12'h0,   32'h0,        1'b0, 5'd1, 32'h0000_0000, 1'b1, 0);
    run_op("priv_low",   enc(12'h300, 5'd0, 3'b010, 5'd1), 32'h0,       32'h114, 2'b01, SB_NONE,   1'b0, 12'h0,   32'h0,        1'b0, 5'd1, 32'h0000_0000, 1'b1, 0);
    run_op("mret_s",     32'h30200073,                     32'h0,       32'h118, 2'b01, SB_NONE,   1'b0, 12'h0,   32'h0,        1'b0, 5'd0, 32'h0000_0000, 1'b1, 0);
    run_op("ebreak",     32'h00100073,                     32'h0,       32'h080, 2'b11, SB_EBREAK, 1'b0, 12'h0,   32'h0,        1'b0, 5'd0, 32'h0000_0000, 1'b0, 0);
    run_op("mret_m",     32'h30200073,                     32'h0,       32'h120, 2'b11, SB_MRET,   1'b0, 12'h0,   32'h0,        1'b0, 5'd0, 32'h0000_0000, 1'b0, 0);
    run_op("ro_read",    enc(12'hF11, 5'd0, 3'b010, 5'd1), 32'h0,       32'h124, 2'b11, SB_NONE,   1'b1, 12'hF11, 32'h0,        1'b1, 5'd1, 32'h0000_0055, 1'b0, 0);
    run_op("csrrw_rd0",  enc(12'h340, 5'd3, 3'b001, 5'd0), 32'h0000CAFE, 32'h128, 2'b11, SB_RW,     1'b1, 12'h340, 32'h0000CAFE, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 0);
    run_op("bad_opcode", 32'h00000013,                     32'h0,       32'h12C, 2'b11, SB_NONE,   1'b0, 12'h0,   32'h0,        1'b0, 5'd0, 32'h0000_0000, 1'b1, 0);
    run_op("funct3_100", enc(12'h340, 5'd1, 3'b100, 5'd2), 32'h0,       32'h130, 2'b11, SB_NONE,   1'b0, 12'h0,   32'h0,        1'b0, 5'd2, 32'h0000_0000, 1'b1, 0);
    run_op("bad_sys",    32'h00200073,                     32'h0,       32'h134, 2'b11, SB_NONE,   1'b0, 12'h0,   32'h0,        1'b0, 5'd0, 32'h0000_0000, 1'b1, 0);
    run_op("ecall_u",    32'h00000073,                     32'h0,       32'h138, 2'b00, SB_ECALL,  1'b0, 12'h0,   32'h0,        1'b0, 5'd0, 32'h0000_0000, 1'b0, 0);
    run_op("s_csr_s",    enc(12'h100, 5'd0, 3'b010, 5'd4), 32'h0,       32'h13C, 2'b01, SB_NONE,   1'b1, 12'h100, 32'h0,        1'b1, 5'd4, 32'h0000_0000, 1'b0, 0);
    run_op("stall5",     enc(12'h304, 5'd10, 3'b011, 5'd9), 32'h00000003, 32'h140, 2'b11, SB_RC,   1'b1, 12'h304, 32'h00000003, 1'b1, 5'd9, 32'h0000_001F, 1'b0, 5);
    check("mie_cleared", mie, 32'h0000_001C);

    // Reset asserted during ISSUE: strobe drops at once and the write never lands.
    check("rst_mid_in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_instr   = enc(12'h340, 5'd6, 3'b001, 5'd5);
    bus.in_rs1_val = 32'h12345678;
    bus.in_pc      = 32'h200;
    bus.priv_mode  = 2'b11;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_strobe_before", 32'(sb), 32'(SB_RW));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strobe_after", 32'(sb), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_csr", 32'(bus.csr), 32'd0);
    @(negedge clk);
    check("rst_mid_wb_valid", 32'(bus.wb_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_mscratch", mscratch, 32'h0000CAFE);
    run_op("post_rst",   enc(12'h340, 5'd0, 3'b010, 5'd2), 32'h0,       32'h204, 2'b11, SB_NONE,   1'b1, 12'h340, 32'h0,        1'b1, 5'd2, 32'h0000CAFE, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
